kvadd_example_vec2_adder: RTL and testbench
===========================================

KVADD_EXAMPLE_VEC2_ADDER -- requirements
Module: kvadd_example_vec2_adder

Interface
REQ-001 The block SHALL have parameter C_AXIS_TDATA_WIDTH, default 512: stream data width in bits, a multiple of C_ADDER_BIT_WIDTH.
REQ-002 The block SHALL have parameter C_ADDER_BIT_WIDTH, default 32: lane width; lane count L = C_AXIS_TDATA_WIDTH/C_ADDER_BIT_WIDTH.
REQ-003 The block SHALL have port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port areset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have ports s_axis_a_tvalid (in, 1), s_axis_a_tready (out, 1), s_axis_a_tdata (in, C_AXIS_TDATA_WIDTH) and s_axis_a_tlast (in, 1): the operand-A stream.
REQ-006 The block SHALL have ports s_axis_b_tvalid (in, 1), s_axis_b_tready (out, 1), s_axis_b_tdata (in, C_AXIS_TDATA_WIDTH) and s_axis_b_tlast (in, 1): the operand-B stream.
REQ-007 The block SHALL have ports m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tdata (out, C_AXIS_TDATA_WIDTH) and m_axis_tlast (out, 1): the sum stream consumed by the write master.
REQ-008 The block SHALL have port tlast_err, output, 1 bit: sticky flag for an A/B tlast mismatch.
REQ-009 The block SHALL have port beat_count, output, 32 bits: the count of completed output transfers.

Function
REQ-010 The block SHALL join A and B: an input beat is accepted only in a cycle where a_tvalid, b_tvalid and space are all 1, and space = (occupancy < 2).
REQ-011 The block SHALL drive s_axis_a_tready = s_axis_b_tready = a_tvalid & b_tvalid & space, so that a single-sided valid is never consumed.
REQ-012 For each lane i, the block SHALL compute sum[i] = a[i] + b[i] modulo 2^C_ADDER_BIT_WIDTH (unsigned wrap; carry discarded, no carry between lanes) unless the Configuration feature is enabled.
REQ-013 The block SHALL store each accepted beat {sum, a_tlast | b_tlast} in a 2-entry FIFO with registered outputs; m_axis_* SHALL present the FIFO head.
REQ-014 The block SHALL have a latency of 1 cycle: a beat accepted at edge N appears on m_axis at edge N when the FIFO was empty.
REQ-015 With inputs valid and m_axis_tready held at 1, the block SHALL sustain 1 beat per clock.
REQ-016 On a simultaneous push and pop with occupancy 1, the block SHALL keep occupancy at 1 and present the new beat next cycle.
REQ-017 When occupancy is 2, the block SHALL not accept input that cycle, even if a pop occurs in the same cycle.
REQ-018 The block SHALL hold m_axis_tdata and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-019 The block SHALL not retract m_axis_tvalid before the handshake completes.
REQ-020 The block SHALL set tlast_err to 1 on any accepted beat with a_tlast != b_tlast, and SHALL clear it only by reset.
REQ-021 The block SHALL increment beat_count on each m_axis transfer, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-022 While areset_n=0, the block SHALL clear the FIFO, drive m_axis_tvalid=0, tready outputs=0, tlast_err=0 and beat_count=0; m_axis_tdata and m_axis_tlast are don't-care.
REQ-023 On a mid-transfer reset, the block SHALL discard all in-flight beats, including any beat held under backpressure.
REQ-024 After areset_n deasserts, the block SHALL accept input no earlier than the first rising edge after deassertion.

Configuration
REQ-025 When macro KVADD_VEC2_SATURATE_EN is defined, each lane SHALL saturate to 2^C_ADDER_BIT_WIDTH-1 on unsigned overflow; all other behaviour is unchanged.
REQ-026 When KVADD_VEC2_SATURATE_EN is undefined, the block SHALL use wrap-around per REQ-012, with no saturation logic present.

Verification
REQ-027 The bench SHALL cover: A lane0=0x00000005, B lane0=0x00000003, other lanes 0, ready=1 -> next cycle lane0=0x00000008, other lanes 0, beat_count=1.
REQ-028 The bench SHALL cover: lane0 0xFFFFFFFF+0x00000002 -> 0x00000001 without the macro, and 0xFFFFFFFF with KVADD_VEC2_SATURATE_EN; lane1 is unaffected in both cases.
REQ-029 The bench SHALL cover: A valid for 5 cycles while B stays low -> no A beat consumed, m_axis_tvalid=0; B then rises -> exactly one beat is produced.
REQ-030 The bench SHALL cover: 16-beat streams with m_axis_tready=0 for cycles 3-10 -> the FIFO holds 2 beats, inputs stall, output tdata stays stable, all 16 sums arrive in order and beat_count=16.
REQ-031 The bench SHALL cover: a_tlast=1 with b_tlast=0 on beat 4 -> tlast_err=1 from the next cycle, m_axis_tlast=1 on that beat, and tlast_err remains set.
REQ-032 The bench SHALL cover: areset_n pulsed low with 2 beats queued -> m_axis_tvalid=0 immediately, and beat_count=0 and tlast_err=0 after release.

Source files
------------

// File: rtl/kvadd_example_vec2_adder.sv
// Lane-wise vector adder: joins two AXI-Stream operands and queues the sums in a 2-entry output FIFO.
// Optional macro KVADD_VEC2_SATURATE_EN makes each lane saturate on unsigned overflow instead of wrapping.
module kvadd_example_vec2_adder #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic                          s_axis_a_tvalid,
  output logic                          s_axis_a_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_a_tdata,
  input  logic                          s_axis_a_tlast,
  input  logic                          s_axis_b_tvalid,
  output logic                          s_axis_b_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_b_tdata,
  input  logic                          s_axis_b_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          tlast_err,
  output logic [31:0]                   beat_count
);
  localparam int AW    = C_ADDER_BIT_WIDTH;
  localparam int LANES = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;

  function automatic logic [AW-1:0] lane_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
`ifdef KVADD_VEC2_SATURATE_EN
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    lane_add = s[AW] ? {AW{1'b1}} : s[AW-1:0];
`else
    lane_add = a + b;
`endif
  endfunction

  logic [C_AXIS_TDATA_WIDTH-1:0] w_sum;
  logic                          w_last;
  logic                          w_space;
  logic                          w_push;
  logic                          w_pop;
  logic [1:0]                    w_cnt_nxt;

  logic [1:0]                    r_cnt;
  logic                          r_mvld;
  logic                          r_tlast_err;
  logic [31:0]                   r_beat_count;
  logic [C_AXIS_TDATA_WIDTH-1:0] r_head_data;
  logic                          r_head_last;
  logic [C_AXIS_TDATA_WIDTH-1:0] r_tail_data;
  logic                          r_tail_last;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum[i*AW +: AW] = lane_add(s_axis_a_tdata[i*AW +: AW], s_axis_b_tdata[i*AW +: AW]);
    end
  end

  assign w_last  = s_axis_a_tlast | s_axis_b_tlast;
  // A full FIFO refuses input even when the head drains this cycle; reset also forces ready low.
  assign w_space = areset_n & (r_cnt < 2'd2);
  assign w_push  = s_axis_a_tvalid & s_axis_b_tvalid & w_space;
  assign w_pop   = r_mvld & m_axis_tready;

  assign s_axis_a_tready = w_push;
  assign s_axis_b_tready = w_push;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_cnt        <= 2'd0;
      r_mvld       <= 1'b0;
      r_tlast_err  <= 1'b0;
      r_beat_count <= 32'd0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_mvld <= (w_cnt_nxt != 2'd0);
      if (w_push && (s_axis_a_tlast != s_axis_b_tlast)) begin
        r_tlast_err <= 1'b1;
      end
      if (w_pop) begin
        r_beat_count <= r_beat_count + 32'd1;
      end
    end
  end

  // Payload registers carry no reset; their content is only meaningful while r_mvld is set.
  always_ff @(posedge aclk) begin
    if (w_pop && (r_cnt == 2'd2)) begin
      r_head_data <= r_tail_data;
      r_head_last <= r_tail_last;
    end else if (w_push && ((r_cnt == 2'd0) || w_pop)) begin
      r_head_data <= w_sum;
      r_head_last <= w_last;
    end
    if (w_push && (r_cnt == 2'd1) && !w_pop) begin
      r_tail_data <= w_sum;
      r_tail_last <= w_last;
    end
  end

  assign m_axis_tvalid = r_mvld;
  assign m_axis_tdata  = r_head_data;
  assign m_axis_tlast  = r_head_last;
  assign tlast_err     = r_tlast_err;
  assign beat_count    = r_beat_count;

endmodule

// File: tb/tb_kvadd_example_vec2_adder.sv
// Randomised and directed bench for kvadd_example_vec2_adder against a queue-based reference model.
module tb_kvadd_example_vec2_adder;
  localparam int W  = 512;
  localparam int AW = 32;
  localparam int L  = W / AW;

  logic         aclk = 1'b0;
  logic         areset_n;
  logic         av, bv, al, bl, mrdy;
  logic [W-1:0] ad, bd;
  logic         a_rdy, b_rdy, m_vld, m_last, t_err;
  logic [W-1:0] m_data;
  logic [31:0]  b_cnt;

  int checks   = 0;
  int failures = 0;

  kvadd_example_vec2_adder #(.C_AXIS_TDATA_WIDTH(W), .C_ADDER_BIT_WIDTH(AW)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_axis_a_tvalid(av), .s_axis_a_tready(a_rdy), .s_axis_a_tdata(ad), .s_axis_a_tlast(al),
    .s_axis_b_tvalid(bv), .s_axis_b_tready(b_rdy), .s_axis_b_tdata(bd), .s_axis_b_tlast(bl),
    .m_axis_tvalid(m_vld), .m_axis_tready(mrdy), .m_axis_tdata(m_data), .m_axis_tlast(m_last),
    .tlast_err(t_err), .beat_count(b_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference sum: each lane added as plain integers, then wrapped or clamped.
  function automatic logic [W-1:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    longint unsigned s;
    r = '0;
    for (int i = 0; i < L; i++) begin
      s = longint'(a[i*AW +: AW]) + longint'(b[i*AW +: AW]);
`ifdef KVADD_VEC2_SATURATE_EN
      if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`else
      s = s % 64'h1_0000_0000;
`endif
      r[i*AW +: AW] = s[AW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < L; i++) begin
      case ($urandom_range(0, 7))
        0:       v[i*AW +: AW] = 32'hFFFF_FFFF;
        1:       v[i*AW +: AW] = 32'h0;
        default: v[i*AW +: AW] = $urandom;
      endcase
    end
    return v;
  endfunction

  typedef struct { logic [W-1:0] d; logic l; } beat_t;
  beat_t       mq[$];
  int unsigned m_cnt = 0;
  logic        m_err = 1'b0;

  always @(posedge aclk or negedge areset_n) begin : model
    bit    pop, push;
    beat_t nb;
    if (!areset_n) begin
      mq.delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      pop  = (mq.size() > 0) && mrdy;
      push = av && bv && (mq.size() < 2);
      nb.d = model_sum(ad, bd);
      nb.l = al | bl;
      if (push && (al != bl)) m_err = 1'b1;
      if (pop) begin
        void'(mq.pop_front());
        m_cnt++;
      end
      if (push) mq.push_back(nb);
    end
  end

  always @(negedge aclk) begin
    if (!areset_n) begin
      chk("rst_m_tvalid", m_vld, 0);
      chk("rst_a_tready", a_rdy, 0);
      chk("rst_b_tready", b_rdy, 0);
      chk("rst_tlast_err", t_err, 0);
      chk("rst_beat_count", b_cnt, 0);
    end else begin
      chk("m_tvalid", m_vld, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("m_tdata", m_data, mq[0].d);
        chk("m_tlast", m_last, mq[0].l);
      end
      chk("a_tready", a_rdy, av && bv && (mq.size() < 2));
      chk("b_tready", b_rdy, av && bv && (mq.size() < 2));
      chk("tlast_err", t_err, m_err);
      chk("beat_count", b_cnt, m_cnt);
    end
  end

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic reset_pulse();
    areset_n = 1'b0;
    step();
    step();
    areset_n = 1'b1;
  endtask

  logic [W-1:0] exp_v, hold, av_arr[16], bv_arr[16], sums[16];
  int           n, k, got, c;
  logic         acc;

  initial begin
    areset_n = 1'b1; av = 0; bv = 0; al = 0; bl = 0; mrdy = 0; ad = '0; bd = '0;
    #1 areset_n = 1'b0;
    repeat (3) step();
    chk("lit_rst_tvalid", m_vld, 0);
    chk("lit_rst_count", b_cnt, 0);
    areset_n = 1'b1;

    // 5 + 3 in lane 0
    ad = '0; bd = '0; ad[31:0] = 32'd5; bd[31:0] = 32'd3; av = 1; bv = 1; mrdy = 1;
    step();
    av = 0; bv = 0;
    exp_v = '0; exp_v[31:0] = 32'd8;
    chk("lit_add_tvalid", m_vld, 1);
    chk("lit_add_tdata", m_data, exp_v);
    step();
    chk("lit_add_count", b_cnt, 1);

    // lane-0 overflow, lane 1 independent
    ad = '0; bd = '0; ad[31:0] = 32'hFFFF_FFFF; bd[31:0] = 32'h2; ad[63:32] = 32'h1234; bd[63:32] = 32'h10;
    av = 1; bv = 1;
    step();
    av = 0; bv = 0;
    exp_v = '0;
`ifdef KVADD_VEC2_SATURATE_EN
    exp_v[31:0] = 32'hFFFF_FFFF;
`else
    exp_v[31:0] = 32'h0000_0001;
`endif
    exp_v[63:32] = 32'h1244;
    chk("lit_ovf_tdata", m_data, exp_v);
    step();

    // A alone must not be consumed
    av = 1; bv = 0; ad = rand_vec(); bd = rand_vec();
    repeat (5) begin
      step();
      chk("lit_join_a_tready", a_rdy, 0);
      chk("lit_join_tvalid", m_vld, 0);
    end
    bv = 1;
    #1 chk("lit_join_ready_both", a_rdy, 1);
    step();
    av = 0; bv = 0; n = 0;
    repeat (4) begin
      if (m_vld) n++;
      step();
    end
    chk("lit_join_one_beat", n, 1);

    // 16 beats with output stalled for cycles 3..10
    reset_pulse();
    for (int i = 0; i < 16; i++) begin
      av_arr[i] = rand_vec(); bv_arr[i] = rand_vec(); sums[i] = model_sum(av_arr[i], bv_arr[i]);
    end
    k = 0; got = 0; c = 0; hold = '0;
    while (got < 16 && c < 200) begin
      mrdy = !(c >= 3 && c <= 10);
      if (k < 16) begin av = 1; bv = 1; ad = av_arr[k]; bd = bv_arr[k]; end
      else begin av = 0; bv = 0; end
      #1;
      acc = a_rdy;
      if (m_vld && mrdy) begin
        chk("lit_stream_data", m_data, sums[got]);
        got++;
      end
      if (c == 4) hold = m_data;
      if (c == 9) chk("lit_stall_ready", a_rdy, 0);
      if (c == 10) chk("lit_stall_stable", m_data, hold);
      step();
      if (acc) k++;
      c++;
    end
    av = 0; bv = 0; mrdy = 1;
    chk("lit_stream_count", got, 16);
    chk("lit_stream_beat_count", b_cnt, 16);

    // tlast mismatch on the fourth beat
    for (int i = 0; i < 6; i++) begin
      av = 1; bv = 1; ad = rand_vec(); bd = rand_vec(); al = (i == 3); bl = 0;
      step();
      chk("lit_err_flag", t_err, i >= 3);
      if (i == 3) chk("lit_err_tlast", m_last, 1);
    end
    av = 0; bv = 0; al = 0;
    step();
    step();
    chk("lit_err_sticky", t_err, 1);

    // reset with two beats queued under backpressure
    mrdy = 0; av = 1; bv = 1; ad = rand_vec(); bd = rand_vec();
    step();
    step();
    av = 0; bv = 0;
    chk("lit_q2_tvalid", m_vld, 1);
    #1 areset_n = 1'b0;
    #1 chk("lit_q2_rst_tvalid", m_vld, 0);
    step();
    areset_n = 1'b1;
    step();
    chk("lit_q2_count", b_cnt, 0);
    chk("lit_q2_err", t_err, 0);

    // random traffic
    repeat (600) begin
      av = ($urandom_range(0, 3) != 0);
      bv = ($urandom_range(0, 3) != 0);
      ad = rand_vec(); bd = rand_vec();
      al = ($urandom_range(0, 3) == 0);
      bl = al ^ ($urandom_range(0, 31) == 0);
      mrdy = ($urandom_range(0, 2) != 0);
      step();
    end
    av = 0; bv = 0; mrdy = 1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
